// File: rtl/cmp_pkg.sv
// Shared types and helpers for the round-robin compare arbiter.
package cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } cmp_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick
    import cmp_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            any_o,
    output logic [IDW-1:0]  grant_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        any_o   = |req_i;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_i) + k) % NREQ;
            if (!found && req_i[IDW'(idx)]) begin
                found   = 1'b1;
                grant_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared unsigned magnitude comparator with valid/ready result port.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDW   = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       ack,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_gt,
    output logic                  rsp_lt,
    output logic                  rsp_eq
);

    cmp_state_e       state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .grant_o (pick_idx)
    );

    // Operand slice of the winner and the pointer just past it.
    always_comb begin
        a_sel = a_in[32'(pick_idx)*WIDTH +: WIDTH];
        b_sel = b_in[32'(pick_idx)*WIDTH +: WIDTH];
        ptr_d = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            ack       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gt    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack <= '0;
                    if (pick_any) begin
                        op_a_q  <= a_sel;
                        op_b_q  <= b_sel;
                        id_q    <= pick_idx;
                        ack     <= NREQ'(1) << pick_idx;
                        ptr_q   <= ptr_d;
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    ack       <= '0;
                    rsp_gt    <= op_a_q > op_b_q;
                    rsp_lt    <= op_a_q < op_b_q;
                    rsp_eq    <= op_a_q == op_b_q;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state_q   <= S_RESP;
                end
                S_RESP: begin
                    // Result held until the consumer takes it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_gt    <= 1'b0;
                        rsp_lt    <= 1'b0;
                        rsp_eq    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_cmp_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_v = '0;
    logic [NREQ*WIDTH-1:0] a_v = '0;
    logic [NREQ*WIDTH-1:0] b_v = '0;
    logic                  rdy_v = 1'b0;
    logic [NREQ-1:0]       ack;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_gt, rsp_lt, rsp_eq;

    cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req_v),
        .a_in      (a_v),
        .b_in      (b_v),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rdy_v),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit auto_drop = 1'b1;

    // Reference: a transaction is granted, then its result appears, then waits for ready.
    int       m_ptr, m_phase, m_id, p_id;
    logic [NREQ-1:0] m_ack;
    logic     m_valid, m_gt, m_lt, m_eq, p_gt, p_lt, p_eq;
    int       served[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_phase = 0; m_id = 0; p_id = 0;
        m_ack = '0; m_valid = 0;
        m_gt = 0; m_lt = 0; m_eq = 0; p_gt = 0; p_lt = 0; p_eq = 0;
    endtask

    task automatic model_step();
        int av, bv, g;
        bit found;
        case (m_phase)
            0: begin
                m_ack = '0;
                found = 0;
                g = 0;
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (!found && req_v[i]) begin found = 1; g = i; end
                end
                if (found) begin
                    av = int'((a_v >> (g*WIDTH)) & 16'hF);
                    bv = int'((b_v >> (g*WIDTH)) & 16'hF);
                    p_gt = av > bv; p_lt = av < bv; p_eq = av == bv;
                    p_id = g;
                    m_ack = '0;
                    m_ack[g] = 1'b1;
                    m_ptr = (g + 1) % NREQ;
                    served.push_back(g);
                    m_phase = 1;
                end
            end
            1: begin
                m_ack = '0;
                m_valid = 1; m_id = p_id;
                m_gt = p_gt; m_lt = p_lt; m_eq = p_eq;
                m_phase = 2;
            end
            default: begin
                if (rdy_v) begin
                    m_valid = 0; m_gt = 0; m_lt = 0; m_eq = 0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("ack", 32'(ack), 32'(m_ack));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'({m_gt, m_lt, m_eq}));
        if (m_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("onehot", 32'(rsp_gt) + 32'(rsp_lt) + 32'(rsp_eq), 32'd1);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_outputs();
        if (auto_drop) req_v = req_v & ~m_ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        chk("rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_v[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_v[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic single(input int a, input int b);
        set_op(0, a, b);
        req_v = 4'b0001;
        rdy_v = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset while a result is pending.
        set_op(0, 3, 9);
        req_v = 4'b0001; rdy_v = 1'b0;
        repeat (3) tick();
        chk("pending_before_rst", 32'(rsp_valid), 32'd1);
        do_reset();
        single(5, 2);

        // Single transaction and the three compare outcomes.
        single(1, 8);
        single(4, 4);
        single(15, 0);
        single(0, 15);

        // Round-robin over all requesters, then 1001 from pointer 0.
        do_reset();
        served.delete();
        req_v = 4'b1111; rdy_v = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, i * 3, 7);
            repeat (3) tick();
        end
        req_v = 4'b1001;
        repeat (6) tick();
        chk("rr_count", 32'(served.size()), 32'd6);
        for (int i = 0; i < 6 && i < served.size(); i++)
            chk("rr_order", 32'(served[i]), (i < 4) ? 32'(i) : ((i == 4) ? 32'd0 : 32'd3));

        // Backpressure: result held for 5 cycles with other requests waiting.
        set_op(1, 9, 9);
        req_v = 4'b0010; rdy_v = 1'b0;
        repeat (2) tick();
        req_v = 4'b1111;
        auto_drop = 1'b0;
        repeat (5) tick();
        rdy_v = 1'b1;
        tick();
        chk("bp_drop", 32'(rsp_valid), 32'd0);
        req_v = '0;
        auto_drop = 1'b1;
        repeat (2) tick();

        // Wrap with a withdrawn request: serve id 2 so the pointer lands on 3.
        do_reset();
        req_v = 4'b0100; rdy_v = 1'b1;
        tick();
        req_v = 4'b0100;
        tick();
        req_v = 4'b0001;
        set_op(0, 6, 2);
        repeat (4) tick();
        chk("wrap_ptr_served", 32'(served[served.size()-1]), 32'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && ($urandom % 4 == 0)) req_v[i] = 1'b1;
                else if (req_v[i] && ($urandom % 16 == 0)) req_v[i] = 1'b0;
            end
            a_v = 16'($urandom);
            b_v = ($urandom % 5 == 0) ? a_v : 16'($urandom);
            rdy_v = ($urandom % 3 != 0);
            if (c == 300) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
